// File: rtl/iq_pkg.sv
// Shared definitions for the IQ stream packer: mode codes, word layout,
// sequencer states and the sample sign-extension helper.
package iq_pkg;

  localparam logic [1:0] MODE_IQ   = 2'd0;
  localparam logic [1:0] MODE_TEST = 2'd1;

  // Packed word layout: I in the low half, Q in the high half.
  localparam int HALF_W     = 16;
  localparam int WORD_I_LSB = 0;
  localparam int WORD_Q_LSB = 16;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_EMIT = 1'b1
  } seq_state_e;

  // Sign-extend the low sw bits of x to 16 bits.
  function automatic logic [15:0] sext16(input logic [15:0] x, input int sw);
    logic signed [15:0] t;
    t = $signed(x << (16 - sw));
    return 16'(t >>> (16 - sw));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO. The read data port shows the
// head entry whenever the FIFO is non-empty and reads as zero when empty.
module sync_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_ok, rd_ok;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A write into a full FIFO is only taken when the head leaves the same cycle.
  assign rd_ok     = rd_en_i && !empty_o;
  assign wr_ok     = wr_en_i && (!full_o || rd_ok);
  assign rd_data_o = empty_o ? '0 : mem[rd_ptr_q[AW-1:0]];

  // Pointer advance for accepted reads and writes.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers; contents are discarded by reset via the pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/iq_stream_packer.sv
// Packs one strobe of NCH parallel I/Q pairs into a serial stream of 32-bit
// words (one per enabled channel) through an output FIFO, with a test
// counter mode and a saturating count of vectors dropped while busy.
module iq_stream_packer
  import iq_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int SW         = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [NCH-1:0]    ch_mask,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [NCH*SW-1:0] in_i,
  input  logic [NCH*SW-1:0] in_q,
  output logic [31:0]       out_data,
  output logic [1:0]        out_ch,
  output logic              out_first,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int FW = 35;

  seq_state_e        state_q, state_d;
  logic [NCH*SW-1:0] cap_i_q, cap_i_d, cap_q_q, cap_q_d;
  logic [NCH-1:0]    rem_q, rem_d;
  logic [1:0]        cap_mode_q, cap_mode_d;
  logic              first_q, first_d;
  logic [31:0]       tcnt_q, tcnt_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic [1:0]        sel_ch;
  logic [NCH-1:0]    sel_bit, rem_after;
  logic [31:0]       word;
  logic              push, pop, full, empty;
  logic [FW-1:0]     push_word, pop_word;

  assign busy      = (state_q == SEQ_EMIT);
  assign pop       = out_ready && !empty;
  assign push      = busy && (!full || pop);
  assign rem_after = rem_q & ~sel_bit;
  assign push_word = {first_q, sel_ch, word};
  assign out_valid = !empty;
  assign {out_first, out_ch, out_data} = pop_word;
  assign drop_cnt  = drop_q;

  // Lowest remaining enabled channel wins.
  always_comb begin
    sel_ch  = '0;
    sel_bit = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (rem_q[k]) begin
        sel_ch     = 2'(k);
        sel_bit    = '0;
        sel_bit[k] = 1'b1;
      end
    end
  end

  // Word for the selected channel; reserved modes pack like IQ.
  always_comb begin
    word = '0;
    if (cap_mode_q == MODE_TEST) begin
      word = tcnt_q;
    end else begin
      word[WORD_I_LSB +: HALF_W] = sext16(16'(cap_i_q[int'(sel_ch)*SW +: SW]), SW);
      word[WORD_Q_LSB +: HALF_W] = sext16(16'(cap_q_q[int'(sel_ch)*SW +: SW]), SW);
    end
  end

  // Sequencer next state, capture register and counters.
  always_comb begin
    state_d    = state_q;
    cap_i_d    = cap_i_q;
    cap_q_d    = cap_q_q;
    rem_d      = rem_q;
    cap_mode_d = cap_mode_q;
    first_d    = first_q;
    tcnt_d     = tcnt_q;
    drop_d     = drop_q;
    case (state_q)
      SEQ_IDLE: begin
        if (in_valid && (ch_mask != '0)) begin
          cap_i_d    = in_i;
          cap_q_d    = in_q;
          rem_d      = ch_mask;
          cap_mode_d = mode;
          first_d    = 1'b1;
          state_d    = SEQ_EMIT;
        end
      end
      SEQ_EMIT: begin
        if (push) begin
          rem_d   = rem_after;
          first_d = 1'b0;
          if (rem_after == '0) state_d = SEQ_IDLE;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
    if (clr) begin
      tcnt_d = '0;
      drop_d = '0;
    end else begin
      if (push) tcnt_d = tcnt_q + 32'd1;
      if (busy && in_valid && (drop_q != {CNT_W{1'b1}})) drop_d = drop_q + CNT_W'(1);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEQ_IDLE;
      cap_i_q    <= '0;
      cap_q_q    <= '0;
      rem_q      <= '0;
      cap_mode_q <= MODE_IQ;
      first_q    <= 1'b0;
      tcnt_q     <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      cap_i_q    <= cap_i_d;
      cap_q_q    <= cap_q_d;
      rem_q      <= rem_d;
      cap_mode_q <= cap_mode_d;
      first_q    <= first_d;
      tcnt_q     <= tcnt_d;
      drop_q     <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (push),
    .wr_data_i (push_word),
    .rd_en_i   (pop),
    .rd_data_o (pop_word),
    .full_o    (full),
    .empty_o   (empty)
  );

endmodule

// File: tb/tb_iq_stream_packer.sv
// Randomised and directed bench for iq_stream_packer against a queue-based
// behavioural model of the vector sequencer, FIFO and counters.
module tb_iq_stream_packer;

  localparam int NCH   = 2;
  localparam int SW    = 12;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        mode;
  logic [NCH-1:0]    ch_mask;
  logic              clr;
  logic              in_valid;
  logic [NCH*SW-1:0] in_i, in_q;
  logic [31:0]       out_data;
  logic [1:0]        out_ch;
  logic              out_first, out_valid, out_ready, busy;
  logic [CNT_W-1:0]  drop_cnt;

  int checks   = 0;
  int failures = 0;
  int dut_pops = 0;
  int dut_vecs = 0;

  iq_stream_packer #(
    .NCH(NCH), .SW(SW), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .ch_mask(ch_mask), .clr(clr),
    .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
    .out_data(out_data), .out_ch(out_ch), .out_first(out_first),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: words still owed by the current vector, and the FIFO.
  typedef struct {
    logic        first;
    logic [1:0]  ch;
    logic        test;
    logic [31:0] iq;
  } pend_t;

  pend_t       pend_q[$];
  logic [34:0] fifo_q[$];
  int          drop_m;
  logic [31:0] tcnt_m;

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] sx(input logic [SW-1:0] v);
    int s;
    s = int'(v);
    if (s >= (1 << (SW - 1))) s = s - (1 << SW);
    return 16'(s);
  endfunction

  task automatic model_clear();
    pend_q.delete();
    fifo_q.delete();
    drop_m = 0;
    tcnt_m = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit    popped, pushed, was_busy, first;
    pend_t p;
    logic [31:0] d;
    if (!rst_n) begin
      model_clear();
      return;
    end
    was_busy = (pend_q.size() != 0);
    popped   = (fifo_q.size() != 0) && out_ready;
    pushed   = was_busy && ((fifo_q.size() < DEPTH) || popped);
    if (popped) void'(fifo_q.pop_front());
    if (pushed) begin
      p = pend_q.pop_front();
      d = p.test ? tcnt_m : p.iq;
      fifo_q.push_back({p.first, p.ch, d});
    end
    if (clr) begin
      tcnt_m = '0;
      drop_m = 0;
    end else begin
      if (pushed) tcnt_m = tcnt_m + 32'd1;
      if (was_busy && in_valid && drop_m < (1 << CNT_W) - 1) drop_m++;
    end
    if (!was_busy && in_valid && ch_mask != '0) begin
      first = 1'b1;
      for (int k = 0; k < NCH; k++) begin
        if (ch_mask[k]) begin
          p.first = first;
          p.ch    = 2'(k);
          p.test  = (mode == 2'd1);
          p.iq    = {sx(in_q[k*SW +: SW]), sx(in_i[k*SW +: SW])};
          pend_q.push_back(p);
          first = 1'b0;
        end
      end
    end
  endtask

  // Compare every DUT output that is meaningful this cycle against the model.
  task automatic check();
    bit exp_valid;
    exp_valid = (fifo_q.size() != 0);
    cmp("out_valid", 64'(out_valid), 64'(exp_valid));
    cmp("busy", 64'(busy), 64'(pend_q.size() != 0));
    cmp("drop_cnt", 64'(drop_cnt), 64'(drop_m));
    if (exp_valid) cmp("out_word", 64'({out_first, out_ch, out_data}), 64'(fifo_q[0]));
  endtask

  task automatic tick();
    if (out_valid && out_ready) begin
      dut_pops++;
      if (out_first) dut_vecs++;
    end
    model_step();
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_ch(input int k, input logic [SW-1:0] i, input logic [SW-1:0] q);
    in_i[k*SW +: SW] = i;
    in_q[k*SW +: SW] = q;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'd0; ch_mask = '0; clr = 1'b0; in_valid = 1'b0;
    in_i = '0; in_q = '0; out_ready = 1'b1;
    model_clear();
    #1;
    cmp("rst_out_valid", 64'(out_valid), 64'd0);
    cmp("rst_out_data", 64'(out_data), 64'd0);
    cmp("rst_out_ch", 64'(out_ch), 64'd0);
    cmp("rst_out_first", 64'(out_first), 64'd0);
    cmp("rst_busy", 64'(busy), 64'd0);
    cmp("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    ticks(2);
    rst_n = 1'b1;
    ticks(2);

    // T2: two-channel IQ packing with sign extension.
    ch_mask = 2'b11; mode = 2'd0;
    set_ch(0, 12'h800, 12'h7FF);
    set_ch(1, 12'h001, 12'hFFF);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    tick();
    cmp("t2_w0_data", 64'(out_data), 64'h07FF_F800);
    cmp("t2_w0_ch", 64'(out_ch), 64'd0);
    cmp("t2_w0_first", 64'(out_first), 64'd1);
    tick();
    cmp("t2_w1_data", 64'(out_data), 64'hFFFF_0001);
    cmp("t2_w1_ch", 64'(out_ch), 64'd1);
    cmp("t2_w1_first", 64'(out_first), 64'd0);
    ticks(3);

    // T3: only channel 1 enabled.
    ch_mask = 2'b10;
    set_ch(1, 12'h123, 12'h8A5);
    for (int v = 0; v < 3; v++) begin
      in_valid = 1'b1; tick(); in_valid = 1'b0;
      tick();
      cmp("t3_ch", 64'(out_ch), 64'd1);
      cmp("t3_first", 64'(out_first), 64'd1);
      cmp("t3_data", 64'(out_data), 64'hF8A5_0123);
    end
    ticks(3);

    // T4: strobe every cycle; one vector per three cycles is accepted.
    ch_mask = 2'b11;
    pulse_clr();
    dut_vecs = 0;
    in_valid = 1'b1;
    ticks(100);
    in_valid = 1'b0;
    ticks(8);
    cmp("t4_drops", 64'(drop_cnt), 64'd66);
    cmp("t4_vectors", 64'(dut_vecs), 64'd34);
    pulse_clr();
    cmp("t4_clr", 64'(drop_cnt), 64'd0);

    // T5: consumer stalled; FIFO fills, sequencer holds, later vectors drop.
    out_ready = 1'b0;
    for (int v = 0; v < 10; v++) begin
      set_ch(0, 12'(v * 2), 12'(v));
      set_ch(1, 12'(v * 2 + 1), 12'(v));
      in_valid = 1'b1; tick(); in_valid = 1'b0;
      ticks(2);
    end
    cmp("t5_busy", 64'(busy), 64'd1);
    cmp("t5_drops", 64'(drop_cnt), 64'd1);
    out_ready = 1'b1;
    dut_pops = 0;
    ticks(30);
    cmp("t5_pops", 64'(dut_pops), 64'd18);
    pulse_clr();

    // T6: test counter mode, then a mode change while busy.
    mode = 2'd1; ch_mask = 2'b01;
    for (int v = 0; v < 4; v++) begin
      in_valid = 1'b1; tick(); in_valid = 1'b0;
      tick();
      cmp("t6_count", 64'(out_data), 64'(v));
      tick();
    end
    mode = 2'd0; ch_mask = 2'b11;
    set_ch(0, 12'h800, 12'h7FF);
    set_ch(1, 12'h001, 12'hFFF);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    mode = 2'd1;
    tick();
    cmp("t6_mode_hold0", 64'(out_data), 64'h07FF_F800);
    tick();
    cmp("t6_mode_hold1", 64'(out_data), 64'hFFFF_0001);
    ticks(3);

    // T1: reset mid-EMIT with three words queued.
    mode = 2'd0; out_ready = 1'b0;
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    ticks(2);
    in_valid = 1'b1; ticks(2); in_valid = 1'b0;
    cmp("t1_pre_busy", 64'(busy), 64'd1);
    cmp("t1_pre_drops", 64'(drop_cnt), 64'd1);
    rst_n = 1'b0;
    #1;
    model_clear();
    cmp("t1_out_valid", 64'(out_valid), 64'd0);
    cmp("t1_busy", 64'(busy), 64'd0);
    cmp("t1_drop_cnt", 64'(drop_cnt), 64'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    ticks(3);

    // Randomised traffic with bursts of back-pressure.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 2) == 0);
      ch_mask   = NCH'($urandom);
      mode      = 2'($urandom);
      clr       = ($urandom_range(0, 60) == 0);
      in_i      = (NCH*SW)'($urandom);
      in_q      = (NCH*SW)'($urandom);
      out_ready = ((n / 200) % 3 == 2) ? ($urandom_range(0, 5) == 0)
                                       : ($urandom_range(0, 3) != 0);
      tick();
    end
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ticks(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
